regfile_port_sched: RTL and testbench

- Sits in front of the single-write/dual-read register file and is the only block allowed to drive its control pins.
- Arbitrates between the decode-stage read requester and the writeback-stage write requester, with valid/ready handshakes on both.
- Guarantees the register file never sees read and write enables asserted in the same cycle.
- Resolves read-after-write ordering against a pending write, and returns read data through a stallable response channel.

---
 rtl/regfile_port_sched.sv | 104 ++++++++++
 tb/tb_regfile_port_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sched.sv
// Port scheduler for the 1W/2R register file: arbitrates decode reads against
// writeback writes and returns read operands through a stallable response channel.
module regfile_port_sched #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        APB_PCLK,
  input  logic        reset,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [4:0]  rd_req_ra0,
  input  logic [4:0]  rd_req_ra1,
  output logic        rd_rsp_valid,
  input  logic        rd_rsp_ready,
  output logic [31:0] rd_rsp_rs0,
  output logic [31:0] rd_rsp_rs1,
  input  logic        wr_req_valid,
  output logic        wr_req_ready,
  input  logic [4:0]  wr_req_wa,
  input  logic [31:0] wr_req_wd,
  output logic [4:0]  rf_wa,
  output logic [4:0]  rf_ra0,
  output logic [4:0]  rf_ra1,
  output logic        rf_write_reg,
  output logic        rf_read_reg,
  output logic [31:0] rf_rd0,
  input  logic [31:0] rf_rs0,
  input  logic [31:0] rf_rs1
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [3:0] StreakMax = 4'(STREAK_MAX);

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       readOk;
  logic       hazard;
  logic       grantWr;
  logic       grantRd;

  // A stalled response pins rf_rs0/rf_rs1, so no read may issue until it drains.
  always_comb begin
    readOk  = rd_req_valid && ((state_q == IDLE) || rd_rsp_ready);
    hazard  = wr_req_valid && (wr_req_wa != 5'd0) &&
              ((wr_req_wa == rd_req_ra0) || (wr_req_wa == rd_req_ra1));
    grantWr = 1'b0;
    grantRd = 1'b0;
    if (!reset) begin
      if (wr_req_valid && readOk) begin
        if (hazard || (streak_q < StreakMax)) begin
          grantWr = 1'b1;
        end else begin
          grantRd = 1'b1;
        end
      end else if (wr_req_valid) begin
        grantWr = 1'b1;
      end else if (readOk) begin
        grantRd = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (grantRd) begin
      state_d = RESP;
    end else if ((state_q == RESP) && rd_rsp_ready) begin
      state_d = IDLE;
    end
    if (grantRd || !rd_req_valid) begin
      streak_d = 4'd0;
    end else if (grantWr && (streak_q < StreakMax)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge APB_PCLK) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Writes to x0 are handshaken but never reach the register file.
  assign wr_req_ready = grantWr;
  assign rf_write_reg = grantWr && (wr_req_wa != 5'd0);
  assign rd_req_ready = grantRd;
  assign rf_read_reg  = grantRd;
  assign rf_wa        = wr_req_wa;
  assign rf_rd0       = wr_req_wd;
  assign rf_ra0       = rd_req_ra0;
  assign rf_ra1       = rd_req_ra1;
  assign rd_rsp_valid = (state_q == RESP);
  assign rd_rsp_rs0   = rf_rs0;
  assign rd_rsp_rs1   = rf_rs1;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a behavioural register file
// attached to the rf_* pins; every step is checked with immediate assertions.
module tb_regfile_port_sched;

  logic        APB_PCLK;
  logic        reset;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [4:0]  rd_req_ra0;
  logic [4:0]  rd_req_ra1;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready;
  logic [31:0] rd_rsp_rs0;
  logic [31:0] rd_rsp_rs1;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [4:0]  wr_req_wa;
  logic [31:0] wr_req_wd;
  logic [4:0]  rf_wa;
  logic [4:0]  rf_ra0;
  logic [4:0]  rf_ra1;
  logic        rf_write_reg;
  logic        rf_read_reg;
  logic [31:0] rf_rd0;
  logic [31:0] rf_rs0;
  logic [31:0] rf_rs1;

  logic [31:0] mem [32];
  int          checks;
  int          errors;
  logic        prevValid;
  logic        prevReady;
  logic        prevReset;

  regfile_port_sched #(.STREAK_MAX(4)) dut (
    .APB_PCLK     (APB_PCLK),
    .reset        (reset),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_ra0   (rd_req_ra0),
    .rd_req_ra1   (rd_req_ra1),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_rs0   (rd_rsp_rs0),
    .rd_rsp_rs1   (rd_rsp_rs1),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_wa    (wr_req_wa),
    .wr_req_wd    (wr_req_wd),
    .rf_wa        (rf_wa),
    .rf_ra0       (rf_ra0),
    .rf_ra1       (rf_ra1),
    .rf_write_reg (rf_write_reg),
    .rf_read_reg  (rf_read_reg),
    .rf_rd0       (rf_rd0),
    .rf_rs0       (rf_rs0),
    .rf_rs1       (rf_rs1)
  );

  initial APB_PCLK = 1'b0;
  always #5 APB_PCLK = ~APB_PCLK;

  // Register file model: registered read ports, no x0 filtering so a leaked x0 write shows up.
  always @(posedge APB_PCLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[1] <= 32'h0000_1111;
      mem[2] <= 32'h0000_2222;
      mem[3] <= 32'h0000_0011;
      rf_rs0 <= 32'd0;
      rf_rs1 <= 32'd0;
    end else begin
      if (rf_write_reg) mem[rf_wa] <= rf_rd0;
      if (rf_read_reg) begin
        rf_rs0 <= mem[rf_ra0];
        rf_rs1 <= mem[rf_ra1];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then checks the always-on invariants.
  task automatic applyStimulus(input logic rst, input logic rv, input logic [4:0] ra0,
                               input logic [4:0] ra1, input logic rspRdy, input logic wv,
                               input logic [4:0] wa, input logic [31:0] wd);
    @(negedge APB_PCLK);
    prevValid    = rd_rsp_valid;
    prevReady    = rd_rsp_ready;
    prevReset    = reset;
    reset        = rst;
    rd_req_valid = rv;
    rd_req_ra0   = ra0;
    rd_req_ra1   = ra1;
    rd_rsp_ready = rspRdy;
    wr_req_valid = wv;
    wr_req_wa    = wa;
    wr_req_wd    = wd;
    #1;
    checkOutput("enables_exclusive", 32'(rf_write_reg && rf_read_reg), 32'd0);
    if (prevValid && !prevReady && !prevReset) begin
      checkOutput("rsp_held_while_stalled", 32'(rd_rsp_valid), 32'd1);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    rd_req_valid = 1'b1;
    rd_req_ra0   = 5'd3;
    rd_req_ra1   = 5'd0;
    rd_rsp_ready = 1'b1;
    wr_req_valid = 1'b1;
    wr_req_wa    = 5'd4;
    wr_req_wd    = 32'd0;

    // Reset with both requesters active: nothing may be granted.
    applyStimulus(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd4, 32'h1);
    checkOutput("reset_rd_ready", 32'(rd_req_ready), 32'd0);
    checkOutput("reset_wr_ready", 32'(wr_req_ready), 32'd0);
    checkOutput("reset_rf_write", 32'(rf_write_reg), 32'd0);
    checkOutput("reset_rf_read", 32'(rf_read_reg), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("idle_rsp_valid", 32'(rd_rsp_valid), 32'd0);

    // Plain read of x3/x0.
    applyStimulus(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("rd1_rf_read", 32'(rf_read_reg), 32'd1);
    checkOutput("rd1_req_ready", 32'(rd_req_ready), 32'd1);
    checkOutput("rd1_rf_ra0", 32'(rf_ra0), 32'd3);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("rd1_rsp_valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("rd1_rs0", rd_rsp_rs0, 32'h11);
    checkOutput("rd1_rs1", rd_rsp_rs1, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("rd1_rsp_done", 32'(rd_rsp_valid), 32'd0);

    // Read-after-write hazard on x5: write first, then the read.
    applyStimulus(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    checkOutput("raw_wr_ready", 32'(wr_req_ready), 32'd1);
    checkOutput("raw_rf_write", 32'(rf_write_reg), 32'd1);
    checkOutput("raw_rd_ready", 32'(rd_req_ready), 32'd0);
    checkOutput("raw_rf_wa", 32'(rf_wa), 32'd5);
    checkOutput("raw_rf_rd0", rf_rd0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("raw_rf_read", 32'(rf_read_reg), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("raw_rsp_valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("raw_rs0", rd_rsp_rs0, 32'hDEAD_BEEF);

    // Stalled response: new read to x7 waits, writes to x7 flow, held data stays put.
    applyStimulus(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("stall_first_read", 32'(rf_read_reg), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 32'h70 + 32'(i));
      checkOutput("stall_no_read", 32'(rf_read_reg), 32'd0);
      checkOutput("stall_wr_ready", 32'(wr_req_ready), 32'd1);
      checkOutput("stall_rf_write", 32'(rf_write_reg), 32'd1);
      checkOutput("stall_rsp_valid", 32'(rd_rsp_valid), 32'd1);
      checkOutput("stall_rs0", rd_rsp_rs0, 32'h11);
      checkOutput("stall_rs1", rd_rsp_rs1, 32'hDEAD_BEEF);
    end
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("stall_release_read", 32'(rf_read_reg), 32'd1);
    checkOutput("stall_release_rs0", rd_rsp_rs0, 32'h11);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("stall_b2b_valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("stall_b2b_rs0", rd_rsp_rs0, 32'h72);

    // Non-hazard write stream: four write grants, then the read is forced through.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'(9 + i), 32'(i));
      checkOutput("streak_wr_ready", 32'(wr_req_ready), 32'd1);
      checkOutput("streak_no_read", 32'(rf_read_reg), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 32'h4);
    checkOutput("streak_forced_read", 32'(rf_read_reg), 32'd1);
    checkOutput("streak_wr_blocked", 32'(wr_req_ready), 32'd0);
    checkOutput("streak_no_write", 32'(rf_write_reg), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("streak_rs0", rd_rsp_rs0, 32'h1111);
    checkOutput("streak_rs1", rd_rsp_rs1, 32'h2222);

    // Hazard write stream to x1 keeps the read out past the streak limit.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 32'hA0 + 32'(i));
      checkOutput("hazard_wr_ready", 32'(wr_req_ready), 32'd1);
      checkOutput("hazard_no_read", 32'(rf_read_reg), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 32'hB0);
    checkOutput("hazard_clear_read", 32'(rf_read_reg), 32'd1);
    checkOutput("hazard_clear_wr", 32'(wr_req_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("hazard_rs0", rd_rsp_rs0, 32'hA5);

    // x0 write is accepted but dropped; a later read of x0 returns zero.
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h1234);
    checkOutput("x0_wr_ready", 32'(wr_req_ready), 32'd1);
    checkOutput("x0_rf_write", 32'(rf_write_reg), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_rf_read", 32'(rf_read_reg), 32'd1);

    // Reset while the x0 response is stalled drops it.
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 32'h66);
    checkOutput("x0_rsp_valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("x0_rs0", rd_rsp_rs0, 32'h0);
    checkOutput("midreset_wr_ready", 32'(wr_req_ready), 32'd0);
    checkOutput("midreset_rf_write", 32'(rf_write_reg), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("midreset_rsp_dropped", 32'(rd_rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
